uart_cmd_assembler: RTL and testbench

Frame assembler downstream of the UART receiver. It takes single received bytes over the receiver's `rdy`/`cmd`/`clr_rdy` handshake and packs them into one multi-byte command word for the command decoder. It acknowledges each byte and discards stalled partial frames on an inter-byte timeout. It presents completed commands with a sticky ready flag that the consumer clears.

---
 rtl/uart_cmd_assembler.sv | 153 +++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// Packs UART receiver bytes (first byte = MS byte) into a BYTES-wide command with an inter-byte timeout.
// Optional trailing checksum byte when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_assembler #(
   parameter int BYTES   = 3,
   parameter int TIMEOUT = 50000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_rdy,
   input  logic [7:0]         rx_data,
   output logic               clr_rx_rdy,
   output logic [8*BYTES-1:0] cmd_out,
   output logic               cmd_rdy,
   input  logic               clr_cmd_rdy,
   output logic               frame_err
);

`ifdef UART_CMD_CHECKSUM_EN
   localparam int FRAME = BYTES + 1;
`else
   localparam int FRAME = BYTES;
`endif
   localparam int CW = $clog2(BYTES + 2);
   localparam logic [CW-1:0] LAST    = CW'(FRAME - 1);
   localparam logic [19:0]   TO_LAST = 20'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      count, count_nxt;
   logic [19:0]        timer, timer_nxt;
   logic [8*BYTES-1:0] shreg, shreg_nxt, shifted, cmd_nxt, frame_word;
   logic               cmd_rdy_nxt, clr_nxt, err_nxt;
   logic               take, final_byte, expire, frame_ok;

   // A byte is only taken when the previous acknowledge is not still in flight.
   assign take       = rx_rdy && !clr_rx_rdy && (state != FULL);
   assign final_byte = take && (state == COLLECT) && (count == LAST);
   assign expire     = (state == COLLECT) && !take && (timer == TO_LAST);
   assign shifted    = {shreg[8*BYTES-9:0], rx_data};

`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0] sum, sum_nxt, sum_fin;
   assign sum_fin    = sum + rx_data;
   assign frame_ok   = (sum_fin == 8'h00);
   assign frame_word = shreg;
`else
   assign frame_ok   = 1'b1;
   assign frame_word = shifted;
`endif

   always_ff @(posedge clk or posedge rst) begin : state_reg
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         timer      <= '0;
         shreg      <= '0;
         cmd_out    <= '0;
         cmd_rdy    <= 1'b0;
         clr_rx_rdy <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         timer      <= timer_nxt;
         shreg      <= shreg_nxt;
         cmd_out    <= cmd_nxt;
         cmd_rdy    <= cmd_rdy_nxt;
         clr_rx_rdy <= clr_nxt;
         frame_err  <= err_nxt;
      end
   end

`ifdef UART_CMD_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin : sum_reg
      if (rst) sum <= 8'h00;
      else     sum <= sum_nxt;
   end
`endif

   always_comb begin : next_state
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = COLLECT;
         COLLECT: begin
            if (final_byte)  state_nxt = frame_ok ? FULL : IDLE;
            else if (expire) state_nxt = IDLE;
         end
         FULL:    if (clr_cmd_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin : outputs
      count_nxt   = count;
      timer_nxt   = timer;
      shreg_nxt   = shreg;
      cmd_nxt     = cmd_out;
      cmd_rdy_nxt = cmd_rdy;
      clr_nxt     = take;
      err_nxt     = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      sum_nxt     = sum;
`endif
      case (state)
         IDLE: begin
            timer_nxt = '0;
            if (take) begin
               shreg_nxt = {{(8*BYTES-8){1'b0}}, rx_data};
               count_nxt = CW'(1);
`ifdef UART_CMD_CHECKSUM_EN
               sum_nxt   = rx_data;
`endif
            end
         end
         COLLECT: begin
            timer_nxt = (timer == 20'hFFFFF) ? timer : timer + 20'd1;
            if (take) begin
               count_nxt = count + CW'(1);
               timer_nxt = '0;
               shreg_nxt = shifted;
`ifdef UART_CMD_CHECKSUM_EN
               sum_nxt   = sum_fin;
`endif
               if (final_byte) begin
                  if (frame_ok) begin
                     cmd_nxt     = frame_word;
                     cmd_rdy_nxt = 1'b1;
                  end else begin
                     count_nxt = '0;
                     shreg_nxt = '0;
                     err_nxt   = 1'b1;
                  end
               end
            end else if (expire) begin
               count_nxt = '0;
               shreg_nxt = '0;
               timer_nxt = '0;
               err_nxt   = 1'b1;
            end
         end
         FULL: begin
            timer_nxt = '0;
            if (clr_cmd_rdy) begin
               cmd_rdy_nxt = 1'b0;
               count_nxt   = '0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Randomized bench for uart_cmd_assembler against a queue-based frame model; honours UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_assembler;
   localparam int BY = 3;
   localparam int TO = 20;
`ifdef UART_CMD_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   localparam int FRAME = BY + int'(CSUM);

   logic            clk = 1'b0;
   logic            rst, rx_rdy, clr_cmd_rdy;
   logic [7:0]      rx_data;
   logic            clr_rx_rdy, cmd_rdy, frame_err;
   logic [8*BY-1:0] cmd_out;

   uart_cmd_assembler #(.BYTES(BY), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
      .clr_rx_rdy(clr_rx_rdy), .cmd_out(cmd_out), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err));

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;
   int cyc = 0, acks = 0, errs = 0, ack_cyc = 0, err_cyc = 0;

   // Reference model: bytes gathered in a queue, idle edges counted since the last capture.
   logic [7:0]      mq[$];
   int              m_idle;
   bit              m_ack, m_err, m_rdy, m_full;
   logic [8*BY-1:0] m_cmd;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_idle = 0; m_ack = 0; m_err = 0; m_rdy = 0; m_full = 0; m_cmd = '0;
   endtask

   task automatic model_step();
      bit nack, nerr;
      int s;
      logic [8*BY-1:0] v;
      nack = 0; nerr = 0;
      if (m_full) begin
         if (clr_cmd_rdy) begin m_full = 0; m_rdy = 0; end
      end else if (rx_rdy && !m_ack) begin
         mq.push_back(rx_data);
         m_idle = 0;
         nack = 1;
         if (mq.size() == FRAME) begin
            s = 0;
            foreach (mq[i]) s += int'(mq[i]);
            if (!CSUM || (s % 256) == 0) begin
               v = '0;
               for (int i = 0; i < BY; i++) v = (v << 8) | (8*BY)'(mq[i]);
               m_cmd = v; m_rdy = 1; m_full = 1;
            end else nerr = 1;
            mq.delete();
         end
      end else if (mq.size() != 0) begin
         m_idle++;
         if (m_idle >= TO) begin mq.delete(); nerr = 1; end
      end
      m_ack = nack; m_err = nerr;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      @(negedge clk);
      cyc++;
      if (clr_rx_rdy) begin acks++; ack_cyc = cyc; end
      if (frame_err)  begin errs++; err_cyc = cyc; end
      chk("cmd_rdy", cmd_rdy, m_rdy);
      chk("clr_rx_rdy", clr_rx_rdy, m_ack);
      chk("frame_err", frame_err, m_err);
      chk("cmd_out", cmd_out, m_cmd);
   endtask

   // Receiver emulation: flag held until the acknowledge is seen, then dropped one edge later.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit auto_clr);
      bit got;
      got = 0;
      rx_data = b; rx_rdy = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         clr_cmd_rdy = auto_clr ? ($urandom_range(3) == 0) : 1'b0;
         tick();
         if (clr_rx_rdy) got = 1;
      end
      chk("ack_wait", got, 1);
      tick();
      rx_rdy = 1'b0;
      for (int i = 0; i < gap; i++) begin
         clr_cmd_rdy = auto_clr ? ($urandom_range(3) == 0) : 1'b0;
         tick();
      end
      clr_cmd_rdy = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int gap);
      logic [7:0] cs;
      cs = 8'h00 - a - b - c;
      send_byte(a, gap, 0);
      send_byte(b, gap, 0);
      send_byte(c, gap, 0);
      if (CSUM) send_byte(cs, gap, 0);
   endtask

   task automatic clear_cmd();
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
   endtask

   initial begin
      int a0, e0, g, r;
      logic [7:0] cs;
      rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
      model_reset();
      repeat (3) tick();
      chk("reset_cmd_out", cmd_out, 0);
      chk("reset_cmd_rdy", cmd_rdy, 0);
      rst = 1'b0;
      tick();

      a0 = acks;
      send_frame(8'hA5, 8'h12, 8'h34, 10);
      chk("gap_acks", acks - a0, FRAME);
      chk("gap_cmd", cmd_out, 24'hA51234);
      chk("gap_rdy", cmd_rdy, 1);

      clear_cmd();
      a0 = acks;
      send_frame(8'h01, 8'h02, 8'h03, 0);
      chk("b2b_acks", acks - a0, FRAME);
      chk("b2b_cmd", cmd_out, 24'h010203);

      clear_cmd();
      e0 = errs;
      send_byte(8'h55, 25, 0);
      chk("to_err_count", errs - e0, 1);
      chk("to_err_delay", err_cyc - ack_cyc, TO);
      chk("to_cmd_rdy", cmd_rdy, 0);
      chk("to_cmd_held", cmd_out, 24'h010203);
      send_frame(8'hAA, 8'hBB, 8'hCC, 2);
      chk("after_to_cmd", cmd_out, 24'hAABBCC);

      // Byte pending while FULL must wait for the consumer clear.
      a0 = acks;
      rx_data = 8'h77; rx_rdy = 1'b1;
      repeat (5) tick();
      chk("full_no_ack", acks - a0, 0);
      chk("full_hold", cmd_out, 24'hAABBCC);
      clear_cmd();
      chk("clr_cmd_rdy", cmd_rdy, 0);
      tick();
      chk("pend_ack", clr_rx_rdy, 1);
      tick();
      rx_rdy = 1'b0;
      send_byte(8'h88, 1, 0);
      send_byte(8'h99, 1, 0);
      cs = 8'h00 - 8'h77 - 8'h88 - 8'h99;
      if (CSUM) send_byte(cs, 1, 0);
      chk("pend_cmd", cmd_out, 24'h778899);

      // Byte arriving in the expiring cycle wins over the timeout.
      clear_cmd();
      e0 = errs;
      send_byte(8'h5A, TO - 2, 0);
      send_byte(8'h6B, TO - 2, 0);
      send_byte(8'h7C, 0, 0);
      cs = 8'h00 - 8'h5A - 8'h6B - 8'h7C;
      if (CSUM) send_byte(cs, 0, 0);
      chk("edge_no_err", errs - e0, 0);
      chk("edge_cmd", cmd_out, 24'h5A6B7C);

      clear_cmd();
      send_byte(8'h11, 2, 0);
      send_byte(8'h22, 2, 0);
      rst = 1'b1;
      #1;
      chk("rst_cmd_out", cmd_out, 0);
      chk("rst_cmd_rdy", cmd_rdy, 0);
      chk("rst_clr_rx", clr_rx_rdy, 0);
      chk("rst_err", frame_err, 0);
      model_reset();
      tick();
      rst = 1'b0;
      send_frame(8'h10, 8'h20, 8'h30, 1);
      chk("post_rst_cmd", cmd_out, 24'h102030);

      if (CSUM) begin
         clear_cmd();
         e0 = errs;
         send_byte(8'h01, 0, 0);
         send_byte(8'h02, 0, 0);
         send_byte(8'h03, 0, 0);
         send_byte(8'hFB, 0, 0);
         chk("cs_bad_err", errs - e0, 1);
         chk("cs_bad_rdy", cmd_rdy, 0);
         chk("cs_bad_cmd", cmd_out, 24'h102030);
      end

      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(9);
         if (r < 6)      g = $urandom_range(3);
         else if (r < 9) g = $urandom_range(15, 4);
         else            g = $urandom_range(TO + 3, TO - 3);
         send_byte(8'($urandom_range(255)), g, 1);
      end
      repeat (TO + 5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
